// File: rtl/riscv_retire_mon.sv
// Retirement monitor: counts retired instructions, captures the last result and
// flags the two-instruction halt sequence. Optional cycle counter: RETIRE_MON_CYCLE_EN.
module riscv_retire_mon #(
  parameter logic [31:0] HALT_INST0 = 32'h00c00093,
  parameter logic [31:0] HALT_INST1 = 32'h00008067
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        RETIRE_VALID,
  input  logic [31:0] RETIRE_INST,
  input  logic [31:0] RETIRE_RESULT,
  output logic [31:0] NUM_INST,
  output logic [31:0] OUTPUT_PORT,
`ifdef RETIRE_MON_CYCLE_EN
  output logic [31:0] CYCLE_CNT,
`endif
  output logic        HALT
);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    HALTED
  } state_t;

  state_t state;
  state_t next_state;
  logic   counted;

  assign counted = RETIRE_VALID && (state != HALTED);

  // Halt-sequence tracker; only counted retires can move it.
  always_comb begin
    next_state = state;
    if (counted) begin
      case (state)
        IDLE: begin
          if (RETIRE_INST == HALT_INST0) next_state = ARMED;
        end
        ARMED: begin
          if (RETIRE_INST == HALT_INST1)      next_state = HALTED;
          else if (RETIRE_INST == HALT_INST0) next_state = ARMED;
          else                                next_state = IDLE;
        end
        default: next_state = state;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= next_state;
  end

  assign HALT = (state == HALTED);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      NUM_INST    <= 32'd0;
      OUTPUT_PORT <= 32'd0;
    end else if (counted) begin
      if (NUM_INST != 32'hFFFFFFFF) NUM_INST <= NUM_INST + 32'd1;
      OUTPUT_PORT <= RETIRE_RESULT;
    end
  end

`ifdef RETIRE_MON_CYCLE_EN
  // Free-running until the halt is seen, then frozen.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      CYCLE_CNT <= 32'd0;
    end else if ((state != HALTED) && (CYCLE_CNT != 32'hFFFFFFFF)) begin
      CYCLE_CNT <= CYCLE_CNT + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_riscv_retire_mon.sv
// Scoreboard bench for riscv_retire_mon: stimulus pushes expected outputs, a
// monitor pops and compares one entry after each sampled clock edge.
module tb_riscv_retire_mon;

  localparam logic [31:0] H0  = 32'h00c00093;
  localparam logic [31:0] H1  = 32'h00008067;
  localparam logic [31:0] NOP = 32'h00000013;

  logic        CLK;
  logic        RST;
  logic        RETIRE_VALID;
  logic [31:0] RETIRE_INST;
  logic [31:0] RETIRE_RESULT;
  logic [31:0] NUM_INST;
  logic [31:0] OUTPUT_PORT;
  logic        HALT;
`ifdef RETIRE_MON_CYCLE_EN
  logic [31:0] CYCLE_CNT;
`endif

  riscv_retire_mon #(.HALT_INST0(H0), .HALT_INST1(H1)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .RETIRE_VALID (RETIRE_VALID),
    .RETIRE_INST  (RETIRE_INST),
    .RETIRE_RESULT(RETIRE_RESULT),
    .NUM_INST     (NUM_INST),
    .OUTPUT_PORT  (OUTPUT_PORT),
`ifdef RETIRE_MON_CYCLE_EN
    .CYCLE_CNT    (CYCLE_CNT),
`endif
    .HALT         (HALT)
  );

  typedef struct {
    logic [31:0] num;
    logic [31:0] out;
    logic        halt;
    logic [31:0] cyc;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: 0 idle, 1 armed, 2 halted
  int          mState;
  logic [31:0] mNum;
  logic [31:0] mOut;
  logic [31:0] mCyc;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic exp_t curExp();
    exp_t e;
    e.num  = mNum;
    e.out  = mOut;
    e.halt = (mState == 2);
    e.cyc  = mCyc;
    return e;
  endfunction

  // Monitor: outputs are compared just after every edge that has an expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        total++;
        if (NUM_INST !== e.num || OUTPUT_PORT !== e.out || HALT !== e.halt) begin
          bad++;
          $display("[TB] FAIL sb_outputs: got num=%h out=%h halt=%b, want num=%h out=%h halt=%b",
                   NUM_INST, OUTPUT_PORT, HALT, e.num, e.out, e.halt);
        end
`ifdef RETIRE_MON_CYCLE_EN
        total++;
        if (CYCLE_CNT !== e.cyc) begin
          bad++;
          $display("[TB] FAIL sb_cycle: got %0d want %0d", CYCLE_CNT, e.cyc);
        end
`endif
      end
    end
  end

  task automatic applyStimulus(input logic v, input logic [31:0] inst, input logic [31:0] res);
    @(negedge CLK);
    RETIRE_VALID  = v;
    RETIRE_INST   = inst;
    RETIRE_RESULT = res;
    if (mState != 2 && mCyc != 32'hFFFFFFFF) mCyc = mCyc + 1;
    if (v && mState != 2) begin
      if (mNum != 32'hFFFFFFFF) mNum = mNum + 1;
      mOut = res;
      if (mState == 0) mState = (inst == H0) ? 1 : 0;
      else             mState = (inst == H1) ? 2 : ((inst == H0) ? 1 : 0);
    end
    sbq.push_back(curExp());
    @(posedge CLK);
    #2;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] num,
                             input logic [31:0] out, input logic halt);
    total++;
    if (NUM_INST !== num || OUTPUT_PORT !== out || HALT !== halt) begin
      bad++;
      $display("[TB] FAIL %s: got num=%h out=%h halt=%b, want num=%h out=%h halt=%b",
               name, NUM_INST, OUTPUT_PORT, HALT, num, out, halt);
    end
  endtask

  task automatic clearModel();
    mState = 0;
    mNum   = 32'd0;
    mOut   = 32'd0;
    mCyc   = 32'd0;
  endtask

  // First cycle after release counts one clock on the cycle counter.
  task automatic releaseReset();
    @(negedge CLK);
    RST          = 1'b0;
    RETIRE_VALID = 1'b0;
    mCyc         = 32'd1;
    sbq.push_back(curExp());
    @(posedge CLK);
    #2;
  endtask

  // Reset for one full edge with a retire present that must be ignored.
  task automatic doReset();
    @(negedge CLK);
    RST           = 1'b1;
    RETIRE_VALID  = 1'b1;
    RETIRE_INST   = H0;
    RETIRE_RESULT = 32'hDEADBEEF;
    clearModel();
    sbq.push_back(curExp());
    @(posedge CLK);
    #2;
    releaseReset();
  endtask

  initial begin
    RST           = 1'b1;
    RETIRE_VALID  = 1'b0;
    RETIRE_INST   = 32'd0;
    RETIRE_RESULT = 32'd0;
    clearModel();

    doReset();
    checkOutput("reset_state", 32'd0, 32'd0, 1'b0);

    for (int i = 1; i <= 5; i++) applyStimulus(1'b1, NOP, i);
    checkOutput("count5", 32'd5, 32'd5, 1'b0);

    doReset();
    checkOutput("retire_in_reset", 32'd0, 32'd0, 1'b0);
    applyStimulus(1'b1, H0, 32'd12);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'd0, 32'd0);
    checkOutput("armed_gap", 32'd1, 32'd12, 1'b0);
    applyStimulus(1'b1, H1, 32'd0);
    checkOutput("halt_gap", 32'd2, 32'd0, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, NOP, 32'd99);
    checkOutput("halt_frozen", 32'd2, 32'd0, 1'b1);

    doReset();
    applyStimulus(1'b1, H0, 32'd12);
    applyStimulus(1'b1, NOP, 32'd7);
    applyStimulus(1'b1, H1, 32'd0);
    checkOutput("broken_seq", 32'd3, 32'd0, 1'b0);

    doReset();
    applyStimulus(1'b1, H0, 32'd12);
    applyStimulus(1'b1, H0, 32'd12);
    applyStimulus(1'b1, H1, 32'd44);
    checkOutput("rearm_halt", 32'd3, 32'd44, 1'b1);

    doReset();
    for (int i = 1; i <= 6; i++) applyStimulus(1'b1, NOP, i);
    applyStimulus(1'b1, H0, 32'd12);
    applyStimulus(1'b0, 32'd0, 32'd0);
    checkOutput("armed_seven", 32'd7, 32'd12, 1'b0);
    @(negedge CLK);
    #2;
    RST = 1'b1;
    #1;
    checkOutput("async_reset", 32'd0, 32'd0, 1'b0);
    clearModel();
    releaseReset();
    applyStimulus(1'b1, H1, 32'd5);
    checkOutput("lone_h1", 32'd1, 32'd5, 1'b0);

    doReset();
    force dut.NUM_INST = 32'hFFFFFFFE;
    #1;
    release dut.NUM_INST;
    mNum = 32'hFFFFFFFE;
    for (int i = 1; i <= 3; i++) applyStimulus(1'b1, NOP, 32'h100 + i);
    checkOutput("saturate", 32'hFFFFFFFF, 32'h103, 1'b0);
    applyStimulus(1'b1, H0, 32'd12);
    applyStimulus(1'b1, H1, 32'd0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'd0, 32'd0);
    checkOutput("saturate_halt", 32'hFFFFFFFF, 32'd0, 1'b1);

    for (int i = 0; i < 20 && sbq.size() > 0; i++) @(posedge CLK);
    #3;
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("[TB] FAIL sb_drain: got %0d pending, want 0", sbq.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/riscv_retire_mon.md
RISCV_RETIRE_MON -- requirements
Module: riscv_retire_mon

Interface
REQ-001 Parameter HALT_INST0, default 32'h00c00093, is the first instruction word of the halt sequence (addi x1,x0,12).
REQ-002 Parameter HALT_INST1, default 32'h00008067, is the second instruction word of the halt sequence (jalr x0,0(x1)).
REQ-003 CLK  input  1  single clock; all state updates on the rising edge.
REQ-004 RST  input  1  asynchronous, active-high reset.
REQ-005 RETIRE_VALID  input  1  one instruction retires this cycle.
REQ-006 RETIRE_INST  input  32  encoding of the retiring instruction.
REQ-007 RETIRE_RESULT  input  32  architectural result of the retiring instruction: rd value, branch condition, or store address.
REQ-008 NUM_INST  output  32  count of retired instructions.
REQ-009 OUTPUT_PORT  output  32  RETIRE_RESULT of the most recently counted retire.
REQ-010 HALT  output  1  halt sequence detected; held until reset.

Function
REQ-011 All outputs shall be registered; each shall update on the rising CLK edge that samples the retire (1-cycle latency).
REQ-012 A counted retire is any cycle with RETIRE_VALID=1 while the FSM is not in HALTED.
REQ-013 On a counted retire, NUM_INST shall increment by 1, saturating at 32'hFFFFFFFF with no wrap-around.
REQ-014 On a counted retire, OUTPUT_PORT shall load RETIRE_RESULT.
REQ-015 Without a counted retire, NUM_INST and OUTPUT_PORT shall hold their values.
REQ-016 The FSM shall have exactly three states: IDLE, ARMED and HALTED.
REQ-017 IDLE -> ARMED on a counted retire with RETIRE_INST==HALT_INST0; otherwise remain in IDLE.
REQ-018 ARMED -> HALTED on a counted retire with RETIRE_INST==HALT_INST1.
REQ-019 ARMED -> ARMED on a counted retire with RETIRE_INST==HALT_INST0.
REQ-020 ARMED -> IDLE on a counted retire with any other RETIRE_INST.
REQ-021 Cycles with RETIRE_VALID=0 shall not change the FSM state; bubbles between the two halt instructions do not break the sequence.
REQ-022 Both halt-sequence instructions shall be counted in NUM_INST, and the HALT_INST1 retire shall update OUTPUT_PORT.
REQ-023 HALT shall be 1 exactly when the state is HALTED, asserting the cycle after the HALT_INST1 retire.
REQ-024 In HALTED, RETIRE_VALID shall be ignored; all outputs freeze until RST.
REQ-025 Outputs shall depend only on registered state; there is no combinational path from the inputs to the outputs.

Reset
REQ-026 While RST=1, regardless of CLK: NUM_INST=0, OUTPUT_PORT=0, HALT=0, FSM=IDLE, and CYCLE_CNT=0 when present.
REQ-027 RST asserted mid-sequence, including in ARMED or HALTED, shall discard all state.
REQ-028 A retire in the same cycle as RST=1 shall not be counted.
REQ-029 The first counted retire after RST deassertion shall set NUM_INST=1.

Configuration
REQ-030 When macro RETIRE_MON_CYCLE_EN is defined, output CYCLE_CNT (32 bits) shall exist.
REQ-031 CYCLE_CNT shall increment every cycle after reset while not HALTED, saturate at 32'hFFFFFFFF, and freeze at its value when HALT asserts.
REQ-032 When RETIRE_MON_CYCLE_EN is undefined, CYCLE_CNT and its counter shall be absent, with all other behaviour identical.

Verification
REQ-033 Count: 5 valid retires of 32'h00000013 with results 1..5 -> NUM_INST=5, OUTPUT_PORT=5, HALT=0.
REQ-034 Halt with a gap: retire HALT_INST0 (result 12), 3 idle cycles, retire HALT_INST1 (result 0) -> HALT=1 the next cycle, NUM_INST=2, OUTPUT_PORT=0; a further 4 retires leave NUM_INST=2.
REQ-035 Broken sequence: HALT_INST0, then 32'h00000013, then HALT_INST1 -> HALT stays 0, NUM_INST=3.
REQ-036 Repeated arm: HALT_INST0, HALT_INST0, HALT_INST1 -> HALT=1, NUM_INST=3.
REQ-037 Reset mid-run: assert RST asynchronously between edges while ARMED with NUM_INST=7 -> all outputs 0 immediately; then a lone HALT_INST1 retire -> HALT=0, NUM_INST=1.
REQ-038 Saturation: force NUM_INST to 32'hFFFFFFFE, then 3 retires -> NUM_INST=32'hFFFFFFFF; with RETIRE_MON_CYCLE_EN defined, CYCLE_CNT freezes at HALT.
